// File: rtl/lsu_align_pkg.sv
// Shared definitions for the load/store alignment unit: access-type codes,
// FSM state codes and the access-size table.
package lsu_align_pkg;

  // Access-type codes carried on req_type from the decode stage
  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  typedef enum logic {
    LSU_IDLE   = 1'b0,
    LSU_SECOND = 1'b1
  } lsu_state_e;

  // Number of bytes touched by an access type; unused codes touch nothing
  function automatic logic [2:0] dm_size(input logic [2:0] dm_type);
    logic [2:0] sz;
    case (dm_type)
      DM_WORD:              sz = 3'd4;
      DM_HALFWORD,
      DM_HALFWORD_UNSIGNED: sz = 3'd2;
      DM_BYTE,
      DM_BYTE_UNSIGNED:     sz = 3'd1;
      default:              sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align_ld_extend.sv
// Load-result extension: takes the right-justified raw load bytes and
// sign- or zero-extends them according to the access type.
module lsu_align_ld_extend
  import lsu_align_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  req_type,
  output logic [31:0] ld_data
);

  logic signed [15:0] half_s;
  logic signed [7:0]  byte_s;

  assign half_s = signed'(raw[15:0]);
  assign byte_s = signed'(raw[7:0]);

  // Select width and extension mode; unused codes return zero
  always_comb begin
    ld_data = '0;
    case (req_type)
      DM_WORD:              ld_data = raw;
      DM_HALFWORD:          ld_data = 32'(half_s);
      DM_HALFWORD_UNSIGNED: ld_data = {16'h0000, raw[15:0]};
      DM_BYTE:              ld_data = 32'(byte_s);
      DM_BYTE_UNSIGNED:     ld_data = {24'h000000, raw[7:0]};
      default:              ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between the EX/MEM register and a word-addressed
// data memory. Generates byte enables and lane-aligned store data, extends
// load results, and splits word-crossing accesses into two memory cycles
// with a one-cycle pipeline stall.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_type,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      ld_data,
  output logic             stall,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [29:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] split_cnt
);

  lsu_state_e       state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]  size;
  logic [1:0]  off;
  logic [1:0]  neg_off;
  logic [3:0]  mask;
  logic [6:0]  lanes;
  logic [2:0]  span;
  logic        split;
  logic [4:0]  sh_lo;
  logic [4:0]  sh_hi;
  logic [31:0] raw;
  logic [31:0] ext_data;

  // Lane math: which byte lanes of the low and high word the request covers
  always_comb begin
    size    = dm_size(req_type);
    off     = req_addr[1:0];
    neg_off = 2'(~off + 2'd1);
    mask    = 4'((5'd1 << size) - 5'd1);
    lanes   = {3'b000, mask} << off;
    span    = {1'b0, off} + size;
    split   = req_valid & (span > 3'd4);
    sh_lo   = {off, 3'b000};
    sh_hi   = {neg_off, 3'b000};
  end

  // FSM next state, memory-side outputs, stall and split counter update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = req_addr[31:2];
    mem_wdata = req_wdata << sh_lo;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          mem_be = lanes[3:0];
          mem_we = req_we & (size != 3'd0);
          if (split) begin
            stall   = 1'b1;
            state_d = LSU_SECOND;
          end
        end
      end
      LSU_SECOND: begin
        mem_addr  = req_addr[31:2] + 30'd1;
        mem_wdata = req_wdata >> sh_hi;
        if (req_valid) begin
          mem_be = {1'b0, lanes[6:4]};
          mem_we = req_we;
        end
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (!rstn) begin
      stall  = 1'b0;
      mem_we = 1'b0;
      mem_be = 4'b0000;
    end
  end

  // Load datapath: align read data and capture the low half of a split load
  always_comb begin
    hold_d = hold_q;
    raw    = mem_rdata >> sh_lo;
    if (state_q == LSU_SECOND) begin
      raw = hold_q | (mem_rdata << sh_hi);
    end else if (split && !req_we) begin
      hold_d = mem_rdata >> sh_lo;
    end
  end

  lsu_align_ld_extend u_ld_extend (
    .raw      (raw),
    .req_type (req_type),
    .ld_data  (ext_data)
  );

  assign ld_data   = rstn ? ext_data : 32'h0000_0000;
  assign split_cnt = cnt_q;

  // State, hold register and split counter; reset abandons a pending second half
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= LSU_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
